// File: rtl/mac_accum.sv
// mac_accum -- burst multiply-accumulate back end.
//
// Sums a burst of len+1 unsigned 8-bit products coming from an upstream
// multiplier stage. It presents a single ACC_W-bit result with a sticky
// overflow flag, and holds that result until downstream takes it.
//
// Parameters
//   ACC_W  accumulator width in bits (legal range 8..24)
//   LEN_W  width of the burst-length field; a burst has len+1 terms
//
// Ports
//   clk         rising-edge system clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle request to begin a burst (honoured only in IDLE)
//   len         burst length minus one, sampled together with start
//   in_valid    product valid from the multiplier stage
//   in_product  unsigned 8-bit product
//   in_ready    high while a product can be accepted (ACCUM only)
//   out_valid   burst result available (DONE only)
//   out_ready   downstream accepts the result
//   out_acc     accumulator register, meaningful while out_valid=1
//   out_ovf     sticky overflow flag for the current burst
//   busy        high whenever the block is not IDLE
//
// Configuration
//   MAC_ACCUM_SAT_EN  when defined, an overflowing add saturates the
//                     accumulator at 2^ACC_W-1. Otherwise the sum wraps
//                     modulo 2^ACC_W. out_ovf is the same either way.

module mac_accum #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_product,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic             ovf_q,   ovf_d;

  // One extra bit on the adder so the carry out of bit ACC_W-1 is visible.
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             xfer;

  assign xfer  = (state_q == ACCUM) && in_valid;
  assign sum   = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_product};
  assign carry = sum[ACC_W];

  // State, counter, accumulator and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic and outputs.
  // cnt_q counts the terms still to come after the current one, so the
  // transfer taken while cnt_q is zero closes the burst.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        in_ready = 1'b1;
        if (xfer) begin
`ifdef MAC_ACCUM_SAT_EN
          // Once pinned at all-ones, any later non-zero term carries
          // again. The accumulator therefore stays saturated for the
          // rest of the burst.
          acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          ovf_d = ovf_q | carry;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_acc = acc_q;
  assign out_ovf = ovf_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum -- directed self-checking bench for mac_accum.
// The DUT is built with ACC_W=10, LEN_W=4. Expected values are hand-computed
// and are selected by MAC_ACCUM_SAT_EN where the overflow behaviour differs.

module tb_mac_accum;

  localparam int AccW = 10;
  localparam int LenW = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [LenW-1:0] len;
  logic            in_valid;
  logic [7:0]      in_product;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [AccW-1:0] out_acc;
  logic            out_ovf;
  logic            busy;

  int checks = 0;
  int errors = 0;

`ifdef MAC_ACCUM_SAT_EN
  localparam int OvfAccExp = 1023;
`else
  localparam int OvfAccExp = 101;
`endif

  mac_accum #(
    .ACC_W(AccW),
    .LEN_W(LenW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_product(in_product),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all control inputs at once.
  task automatic applyStimulus(input logic startV, input int lenV,
                               input logic validV, input int productV,
                               input logic outReadyV);
    start      = startV;
    len        = LenW'(lenV);
    in_valid   = validV;
    in_product = 8'(productV);
    out_ready  = outReadyV;
  endtask

  // Issue start with the given length and step into ACCUM.
  task automatic beginBurst(input int lenV);
    start = 1'b1;
    len   = LenW'(lenV);
    tick();
    start = 1'b0;
  endtask

  // Present one product after 'gap' idle cycles of in_valid=0.
  task automatic sendTerm(input int product, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid   = 1'b1;
    in_product = 8'(product);
    tick();
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid. An expired bound shows up as a failed check.
  task automatic waitResult(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 1);
  endtask

  // Hand the result downstream and confirm the return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    // Reset asserted mid-clock while a burst is in flight.
    beginBurst(3);
    sendTerm(50, 0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy",      32'(busy),      0);
    checkOutput("rst_in_ready",  32'(in_ready),  0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_acc",   32'(out_acc),   0);
    checkOutput("rst_out_ovf",   32'(out_ovf),   0);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("rel_busy",     32'(busy),     0);
    checkOutput("rel_in_ready", 32'(in_ready), 0);

    // Basic burst: 10+20+30+40 on consecutive cycles, out_ready held high.
    out_ready = 1'b1;
    beginBurst(3);
    checkOutput("basic_busy",     32'(busy),     1);
    checkOutput("basic_in_ready", 32'(in_ready), 1);
    sendTerm(10, 0);
    sendTerm(20, 0);
    sendTerm(30, 0);
    checkOutput("basic_early_valid", 32'(out_valid), 0);
    sendTerm(40, 0);
    checkOutput("basic_valid",    32'(out_valid), 1);
    checkOutput("basic_acc",      32'(out_acc),   100);
    checkOutput("basic_ovf",      32'(out_ovf),   0);
    checkOutput("basic_done_rdy", 32'(in_ready),  0);
    tick();
    checkOutput("basic_idle", 32'(busy), 0);
    out_ready = 1'b0;

    // Stalls: 5,6,7 with 2-cycle gaps, then downstream back-pressure.
    beginBurst(2);
    sendTerm(5, 2);
    sendTerm(6, 2);
    sendTerm(7, 2);
    waitResult("stall");
    in_valid   = 1'b1;
    in_product = 8'd99;
    repeat (5) tick();
    in_valid = 1'b0;
    checkOutput("stall_acc_held", 32'(out_acc),   18);
    checkOutput("stall_valid",    32'(out_valid), 1);
    checkOutput("stall_in_ready", 32'(in_ready),  0);
    drain("stall");

    // Overflow: five products of 225 into a 10-bit accumulator.
    beginBurst(4);
    repeat (5) sendTerm(225, 0);
    waitResult("ovf");
    checkOutput("ovf_acc",  32'(out_acc), OvfAccExp);
    checkOutput("ovf_flag", 32'(out_ovf), 1);
    drain("ovf");

    // The next accepted start clears both the flag and the sum.
    beginBurst(0);
    checkOutput("ovf_clr_flag", 32'(out_ovf), 0);
    checkOutput("ovf_clr_acc",  32'(out_acc), 0);
    sendTerm(9, 0);
    waitResult("len0");
    checkOutput("len0_acc", 32'(out_acc), 9);
    checkOutput("len0_ovf", 32'(out_ovf), 0);
    drain("len0");

    // start pulsed during ACCUM must not restart the count or the sum.
    beginBurst(3);
    sendTerm(1, 0);
    start = 1'b1;
    len   = LenW'(0);
    tick();
    start = 1'b0;
    sendTerm(2, 0);
    sendTerm(3, 0);
    checkOutput("ign_early_valid", 32'(out_valid), 0);
    sendTerm(4, 0);
    checkOutput("ign_valid", 32'(out_valid), 1);
    checkOutput("ign_acc",   32'(out_acc),   10);
    drain("ign");

    // Longest burst: len all ones gives 16 terms.
    beginBurst(15);
    repeat (15) sendTerm(1, 0);
    checkOutput("max_early_valid", 32'(out_valid), 0);
    sendTerm(1, 0);
    checkOutput("max_valid", 32'(out_valid), 1);
    checkOutput("max_acc",   32'(out_acc),   16);
    drain("max");

    // Reset after 2 of 4 terms, then a clean 2-term burst.
    beginBurst(3);
    sendTerm(100, 0);
    sendTerm(100, 0);
    #2 rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    beginBurst(1);
    checkOutput("mid_new_acc", 32'(out_acc), 0);
    sendTerm(3, 0);
    sendTerm(4, 0);
    checkOutput("mid_valid", 32'(out_valid), 1);
    checkOutput("mid_acc",   32'(out_acc),   7);
    checkOutput("mid_ovf",   32'(out_ovf),   0);
    drain("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
